// File: rtl/prog_encoder_pkg.sv
// rtl/prog_encoder_pkg.sv - instruction type/sub-op/op code constants, FSM and error enums
package prog_encoder_pkg;

  localparam logic [1:0] typeI   = 2'b00;
  localparam logic [1:0] typeII  = 2'b01;
  localparam logic [1:0] typeIII = 2'b10;
  localparam logic [1:0] typeIV  = 2'b11;

  localparam logic [3:0] iADD   = 4'd0;
  localparam logic [3:0] iMOVER = 4'd1;
  localparam logic [3:0] iMOVEA = 4'd2;
  localparam logic [3:0] iRXOR  = 4'd3;
  localparam logic [3:0] iLUT   = 4'd4;
  localparam logic [3:0] iXOR   = 4'd5;
  localparam logic [3:0] iAND   = 4'd6;
  localparam logic [3:0] iLOAD  = 4'd7;
  localparam logic [3:0] iSTORE = 4'd8;
  localparam logic [3:0] iHALT  = 4'd9;

  localparam logic iiBEQ = 1'b0;
  localparam logic iiBLT = 1'b1;

  localparam logic [1:0] iiiANDI = 2'd0;
  localparam logic [1:0] iiiADDI = 2'd1;
  localparam logic [1:0] iiiSUB  = 2'd2;
  localparam logic [1:0] iiiJUMP = 2'd3;

  localparam logic ivLSR = 1'b0;
  localparam logic ivRSR = 1'b1;

  localparam logic [4:0] oADD   = 5'd0;
  localparam logic [4:0] oMOVER = 5'd1;
  localparam logic [4:0] oMOVEA = 5'd2;
  localparam logic [4:0] oRXOR  = 5'd3;
  localparam logic [4:0] oLUT   = 5'd4;
  localparam logic [4:0] oXOR   = 5'd5;
  localparam logic [4:0] oAND   = 5'd6;
  localparam logic [4:0] oLOAD  = 5'd7;
  localparam logic [4:0] oSTORE = 5'd8;
  localparam logic [4:0] oHALT  = 5'd9;
  localparam logic [4:0] oBEQ   = 5'd10;
  localparam logic [4:0] oBLT   = 5'd11;
  localparam logic [4:0] oANDI  = 5'd12;
  localparam logic [4:0] oADDI  = 5'd13;
  localparam logic [4:0] oSUB   = 5'd14;
  localparam logic [4:0] oJUMP  = 5'd15;
  localparam logic [4:0] oLSR   = 5'd16;
  localparam logic [4:0] oRSR   = 5'd17;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_ENCODE, S_WRITE, S_FINISH, S_ERROR
  } enc_state_t;

  typedef enum logic [1:0] {ERR_NONE, ERR_OP, ERR_RANGE, ERR_OVF} err_code_t;

  function automatic logic [3:0] i_subop(input logic [4:0] op);
    case (op)
      oMOVER:  return iMOVER;
      oMOVEA:  return iMOVEA;
      oRXOR:   return iRXOR;
      oLUT:    return iLUT;
      oXOR:    return iXOR;
      oAND:    return iAND;
      oLOAD:   return iLOAD;
      oSTORE:  return iSTORE;
      oHALT:   return iHALT;
      default: return iADD;
    endcase
  endfunction

endpackage

// File: rtl/prog_encoder_enc_pack.sv
// rtl/prog_encoder_enc_pack.sv - combinational op/operand to 9-bit machine word packer
module enc_pack
  import prog_encoder_pkg::*;
(
  input  logic [4:0] op_i,
  input  logic [5:0] operand_i,
  output logic [8:0] word_o,
  output logic       legal_o,
  output logic       range_ok_o
);

  always_comb begin
    word_o     = '0;
    legal_o    = 1'b0;
    range_ok_o = 1'b1;
    case (op_i)
      oADD, oMOVER, oMOVEA, oRXOR, oLUT, oXOR, oAND, oLOAD, oSTORE, oHALT: begin
        legal_o    = 1'b1;
        word_o     = {typeI, i_subop(op_i), operand_i[2:0]};
        range_ok_o = (operand_i[5:3] == 3'b000);
      end
      // branch offsets use the full 6-bit two's complement field
      oBEQ: begin
        legal_o = 1'b1;
        word_o  = {typeII, iiBEQ, operand_i};
      end
      oBLT: begin
        legal_o = 1'b1;
        word_o  = {typeII, iiBLT, operand_i};
      end
      oANDI: begin
        legal_o    = 1'b1;
        word_o     = {typeIII, iiiANDI, operand_i[4:0]};
        range_ok_o = !operand_i[5];
      end
      oADDI: begin
        legal_o    = 1'b1;
        word_o     = {typeIII, iiiADDI, operand_i[4:0]};
        range_ok_o = !operand_i[5];
      end
      oSUB: begin
        legal_o    = 1'b1;
        word_o     = {typeIII, iiiSUB, operand_i[4:0]};
        range_ok_o = !operand_i[5];
      end
      oJUMP: begin
        legal_o    = 1'b1;
        word_o     = {typeIII, iiiJUMP, operand_i[4:0]};
        range_ok_o = !operand_i[5];
      end
      oLSR: begin
        legal_o = 1'b1;
        word_o  = {typeIV, ivLSR, operand_i};
      end
      oRSR: begin
        legal_o = 1'b1;
        word_o  = {typeIV, ivRSR, operand_i};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/prog_encoder.sv
// rtl/prog_encoder.sv - sequential instruction encoder/loader into instruction memory
// Optional PROG_ENCODER_AUTO_HALT_EN appends a HALT word after a non-HALT Last item.
module prog_encoder
  import prog_encoder_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [4:0]        op_i,
  input  logic [5:0]        operand_i,
  input  logic              last_i,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [8:0]        mem_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [1:0]        err_code_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  enc_state_t        state_q;
  logic [4:0]        op_q;
  logic [5:0]        operand_q;
  logic              last_q;
  logic              in_ready_q;
  logic              mem_wr_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [8:0]        mem_data_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  err_code_t         err_code_q;
  logic [ADDR_W:0]   word_count_q;

  logic [8:0] word_d;
  logic       legal_d;
  logic       range_ok_d;

  enc_pack u_enc_pack (
    .op_i       (op_q),
    .operand_i  (operand_q),
    .word_o     (word_d),
    .legal_o    (legal_d),
    .range_ok_o (range_ok_d)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      operand_q    <= '0;
      last_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= BASE_C;
      mem_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      word_count_q <= '0;
    end else begin
      mem_wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_FINISH, S_ERROR: begin
          if (start_i) begin
            state_q      <= S_ACCEPT;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
            word_count_q <= '0;
            mem_addr_q   <= BASE_C;
          end
        end
        S_ACCEPT: begin
          if (in_valid_i) begin
            op_q       <= op_i;
            operand_q  <= operand_i;
            last_q     <= last_i;
            in_ready_q <= 1'b0;
            state_q    <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          if (!legal_d || !range_ok_d || word_count_q == DEPTH_C) begin
            state_q <= S_ERROR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            if (!legal_d)         err_code_q <= ERR_OP;
            else if (!range_ok_d) err_code_q <= ERR_RANGE;
            else                  err_code_q <= ERR_OVF;
          end else begin
            mem_data_q  <= word_d;
            mem_wr_en_q <= 1'b1;
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          word_count_q <= word_count_q + (ADDR_W+1)'(1);
          // hold the address on the final slot so it never wraps past the window
          if (word_count_q + (ADDR_W+1)'(1) < DEPTH_C)
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
          if (!last_q) begin
            state_q    <= S_ACCEPT;
            in_ready_q <= 1'b1;
          end
`ifdef PROG_ENCODER_AUTO_HALT_EN
          else if (op_q != oHALT) begin
            op_q      <= oHALT;
            operand_q <= '0;
            state_q   <= S_ENCODE;
          end
`endif
          else begin
            state_q <= S_FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign mem_wr_en_o  = mem_wr_en_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign err_code_o   = err_code_q;
  assign word_count_o = word_count_q;

endmodule
